// File: rtl/pll_lock_sequencer.sv
// HDMI pixel-clock PLL bring-up sequencer: pulses the PLL reset, waits for lock with
// timeout and bounded retries, qualifies lock over a window, then releases sys_rst.
module pll_lock_sequencer #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 7
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       req_relock,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fault,
    output logic [7:0] retry_count,
    output logic [7:0] lol_count,
    output logic [2:0] state
);

    localparam int CNT_MAX_A = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                               RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > LOCK_STABLE_CYCLES) ? CNT_MAX_A : LOCK_STABLE_CYCLES;
    localparam int CW        = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] RST_LAST    = CW'(RST_PULSE_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [7:0]    RETRY_MAX   = 8'(MAX_RETRIES);

    localparam logic [2:0] S_RESET_PLL = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_STABILIZE = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [2:0] S_FAULT     = 3'd4;

    logic          sync0;
    logic          locked_s;
    logic [CW-1:0] cnt;
    logic [2:0]    next_state;
    logic          cnt_inc;
    logic          fail;

    always_comb begin
        next_state = state;
        cnt_inc    = 1'b0;
        fail       = 1'b0;
        case (state)
            S_RESET_PLL: begin
                if (cnt == RST_LAST) next_state = S_WAIT_LOCK;
                else                 cnt_inc    = 1'b1;
            end
            S_WAIT_LOCK: begin
                if (locked_s) begin
                    next_state = S_STABILIZE;
                end else if (cnt == TIMEOUT_LAST) begin
                    fail       = 1'b1;
                    next_state = (retry_count == RETRY_MAX) ? S_FAULT : S_RESET_PLL;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_STABILIZE: begin
                // a dropout restarts the lock wait but does not cost a retry
                if (!locked_s)                next_state = S_WAIT_LOCK;
                else if (cnt == STABLE_LAST)  next_state = S_RUN;
                else                          cnt_inc    = 1'b1;
            end
            S_RUN: begin
                if (!locked_s) next_state = S_RESET_PLL;
            end
            S_FAULT: next_state = S_FAULT;
            default: next_state = S_RESET_PLL;
        endcase
        if (req_relock) next_state = S_RESET_PLL;
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state       <= S_RESET_PLL;
            cnt         <= '0;
            pll_rst     <= 1'b1;
            sys_rst     <= 1'b1;
            ready       <= 1'b0;
            fault       <= 1'b0;
            retry_count <= '0;
            lol_count   <= '0;
            sync0       <= 1'b0;
            locked_s    <= 1'b0;
        end else begin
            sync0    <= pll_locked;
            locked_s <= sync0;
            state    <= next_state;

            // relock from RESET_PLL does not change state but must restart the pulse
            if (req_relock || next_state != state) cnt <= '0;
            else if (cnt_inc)                      cnt <= cnt + 1'b1;

            pll_rst <= (next_state == S_RESET_PLL) || (next_state == S_FAULT);
            sys_rst <= (next_state != S_RUN);
            ready   <= (next_state == S_RUN);
            fault   <= (next_state == S_FAULT);

            if (req_relock)
                retry_count <= '0;
            else if (fail && retry_count != RETRY_MAX)
                retry_count <= retry_count + 1'b1;
            else if (state == S_STABILIZE && next_state == S_RUN)
                retry_count <= '0;

            if (state == S_RUN && !locked_s && lol_count != 8'hFF)
                lol_count <= lol_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench: stimulus queues the expected state-transition records (outputs plus
// cycles spent in the previous state); a negedge monitor pops one per observed transition.
module tb_pll_lock_sequencer;

    localparam logic [2:0] S_RESET = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_STAB  = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_FAULT = 3'd4;

    logic       refclk;
    logic       rst;
    logic       pll_locked;
    logic       req_relock;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fault;
    logic [7:0] retry_count;
    logic [7:0] lol_count;
    logic [2:0] state;

    pll_lock_sequencer #(
        .RST_PULSE_CYCLES   (4),
        .LOCK_TIMEOUT_CYCLES(32),
        .LOCK_STABLE_CYCLES (8),
        .MAX_RETRIES        (2)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .req_relock (req_relock),
        .pll_rst    (pll_rst),
        .sys_rst    (sys_rst),
        .ready      (ready),
        .fault      (fault),
        .retry_count(retry_count),
        .lol_count  (lol_count),
        .state      (state)
    );

    typedef struct {
        logic [2:0] st;
        logic       prst;
        logic       srst;
        logic       rdy;
        logic       flt;
        logic [7:0] retry;
        logic [7:0] lol;
        int         dwell;   // cycles in the previous state, -1 = don't care
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   lol_e = 0;
    logic mon_en = 1'b0;
    logic done = 1'b0;
    logic rst_q = 1'b0;

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    task automatic tick(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    task automatic push(input logic [2:0] st, input logic prst, input logic srst,
                        input logic rdy, input logic flt, input logic [7:0] retry,
                        input int dwell);
        exp_t e;
        e.st = st; e.prst = prst; e.srst = srst; e.rdy = rdy; e.flt = flt;
        e.retry = retry; e.lol = 8'(lol_e); e.dwell = dwell;
        q.push_back(e);
    endtask

    // From RESET_PLL entry with lock low: pll_locked rises wait_n cycles after pll_rst falls
    task automatic bringup(input int wait_n);
        push(S_WAIT, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 4);
        push(S_STAB, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, wait_n + 3);
        push(S_RUN,  1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8);
        tick(4 + wait_n);
        pll_locked = 1'b1;
        tick(11);
    endtask

    task automatic lose_lock(input int run_dwell);
        pll_locked = 1'b0;
        lol_e = (lol_e < 255) ? lol_e + 1 : 255;
        push(S_RESET, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, run_dwell);
        tick(3);
    endtask

    always @(posedge refclk) rst_q = rst;

    always @(negedge refclk) begin : monitor
        static logic [2:0] prev = 3'd7;
        static int dwell = 0;
        exp_t e;
        if (mon_en) begin
            if (state !== prev) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_transition: state %0d -> %0d, no transition required", prev, state);
                end else begin
                    e = q.pop_front();
                    if (state !== e.st || pll_rst !== e.prst || sys_rst !== e.srst ||
                        ready !== e.rdy || fault !== e.flt || retry_count !== e.retry ||
                        lol_count !== e.lol || (e.dwell >= 0 && dwell != e.dwell)) begin
                        n_err++;
                        $display("FAIL transition @%0t: got st=%0d prst=%b srst=%b rdy=%b flt=%b retry=%0d lol=%0d dwell=%0d; need st=%0d prst=%b srst=%b rdy=%b flt=%b retry=%0d lol=%0d dwell=%0d",
                                 $time, state, pll_rst, sys_rst, ready, fault, retry_count, lol_count, dwell,
                                 e.st, e.prst, e.srst, e.rdy, e.flt, e.retry, e.lol, e.dwell);
                    end
                end
                prev  = state;
                dwell = 1;
            end else begin
                dwell++;
            end
            if (rst_q) dwell = 1;
        end
        if (done) begin
            n_cmp++;
            if (q.size() != 0) begin
                n_err++;
                $display("FAIL pending_transitions: %0d outstanding, need 0", q.size());
            end
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
            $finish;
        end
    end

    initial begin
        rst = 1'b1; pll_locked = 1'b0; req_relock = 1'b0;

        // reset state, then nominal bring-up with lock 10 cycles after pll_rst falls
        push(S_RESET, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, -1);
        tick(1);
        mon_en = 1'b1;
        tick(2);
        rst = 1'b0;
        bringup(10);

        // relock request in RUN with lock stable: lock is already synchronized
        tick(5);
        req_relock = 1'b1;
        push(S_RESET, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 6);
        tick(1);
        req_relock = 1'b0;
        push(S_WAIT, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 4);
        push(S_STAB, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1);
        push(S_RUN,  1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8);
        tick(13);

        // unstable lock: locked_s low when stable count is 5, two-cycle dropout
        lose_lock(3);
        push(S_WAIT, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 4);
        tick(4);
        pll_locked = 1'b1;
        push(S_STAB, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 3);
        tick(6);
        pll_locked = 1'b0;
        push(S_WAIT, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 6);
        tick(2);
        pll_locked = 1'b1;
        push(S_STAB, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 2);
        push(S_RUN,  1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8);
        tick(11);

        // repeated loss of lock: lol_count saturates at 255
        for (int i = 0; i < 300; i++) begin
            lose_lock(3);
            bringup(i % 4);
        end

        // synchronous reset during STABILIZE
        lose_lock(3);
        push(S_WAIT, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 4);
        tick(4);
        pll_locked = 1'b1;
        push(S_STAB, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 3);
        tick(5);
        rst = 1'b1; pll_locked = 1'b0; lol_e = 0;
        push(S_RESET, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, -1);
        tick(1);
        rst = 1'b0;
        bringup(5);

        // synchronous reset during RUN
        tick(2);
        rst = 1'b1; pll_locked = 1'b0; lol_e = 0;
        push(S_RESET, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, -1);
        tick(1);
        rst = 1'b0;
        bringup(7);

        // timeouts: three 32-cycle windows, then FAULT; relock recovers
        lose_lock(3);
        push(S_WAIT,  1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 4);
        push(S_RESET, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 32);
        push(S_WAIT,  1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 4);
        push(S_RESET, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2, 32);
        push(S_WAIT,  1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 4);
        push(S_FAULT, 1'b1, 1'b1, 1'b0, 1'b1, 8'd2, 32);
        tick(108);
        tick(10);
        req_relock = 1'b1;
        push(S_RESET, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 11);
        tick(1);
        req_relock = 1'b0;
        bringup(10);

        tick(3);
        done = 1'b1;
        tick(3);
        $display("FAIL monitor_end: summary not reached, need summary");
        $fatal(1);
    end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
Sequences the HDMI pixel-clock PLL: pulses its reset, waits for lock with a timeout and bounded retries, and qualifies lock over a stability window. It then releases a synchronous reset to the downstream video timing/TMDS logic. While running it monitors for loss of lock and re-sequences automatically. It runs on the 50 MHz reference clock and sits beside the PLL wrapper in the top level.

Parameters:
RST_PULSE_CYCLES, 16, cycles pll_rst is held high per attempt (>=1)
LOCK_TIMEOUT_CYCLES, 65536, max cycles in WAIT_LOCK before an attempt is declared failed (>=2)
LOCK_STABLE_CYCLES, 1024, consecutive synchronized-lock cycles required before release (>=1)
MAX_RETRIES, 7, failed attempts allowed before FAULT (1..255)

Ports:
refclk  in  1  reference clock, 50 MHz; all logic on rising edge
rst  in  1  synchronous, active-high reset
pll_locked  in  1  PLL locked flag, asynchronous; 2-FF synchronized internally to locked_s
req_relock  in  1  single-cycle request to re-run the full sequence (e.g. after reconfiguration)
pll_rst  out  1  reset to PLL
sys_rst  out  1  synchronous reset for pixel-domain logic
ready  out  1  PLL locked and qualified; sys_rst released
fault  out  1  retries exhausted
retry_count  out  8  failed attempts in current sequence
lol_count  out  8  loss-of-lock events while in RUN, saturating at 255
state  out  3  RESET_PLL=0, WAIT_LOCK=1, STABILIZE=2, RUN=3, FAULT=4

Behaviour:
- Reset/synchronicity: one clock, reset synchronous active-high. Every output is a register updated on the same edge as the state register; no combinational outputs.
- On reset: state=RESET_PLL, cnt=0, pll_rst=1, sys_rst=1, ready=0, fault=0, retry_count=0, lol_count=0, sync flops=0.
- rst has priority over every other event.
- Counter width: $clog2(max(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES)+1). cnt clears on every state change.
- RESET_PLL: pll_rst=1, sys_rst=1, ready=0.
  - After exactly RST_PULSE_CYCLES cycles in the state, go to WAIT_LOCK.
- WAIT_LOCK: pll_rst=0, sys_rst=1.
  - locked_s=1 -> STABILIZE.
  - Otherwise cnt increments. When cnt reaches LOCK_TIMEOUT_CYCLES-1 without lock, the attempt fails:
    - if retry_count==MAX_RETRIES -> FAULT;
    - else retry_count+1 and -> RESET_PLL.
- STABILIZE: pll_rst=0, sys_rst=1.
  - locked_s=0 -> WAIT_LOCK. The timeout restarts; this is not a failed attempt.
  - After LOCK_STABLE_CYCLES consecutive cycles with locked_s=1 -> RUN. On that edge sys_rst=0, ready=1, retry_count=0.
- RUN: sys_rst=0, ready=1.
  - locked_s=0 -> RESET_PLL. On the same edge sys_rst=1, ready=0, lol_count+1 (saturating).
- FAULT: pll_rst=1, sys_rst=1, ready=0, fault=1. Exit only via rst or req_relock.
- req_relock, in any state:
  - -> RESET_PLL, cnt=0, retry_count=0, fault=0, sys_rst=1, ready=0.
  - In RUN, a simultaneous lock loss is still counted in lol_count.
- Lock latency: a pll_lock rise that stays high gives state=STABILIZE 3 edges after the rise (2 sync + 1 state). ready rises LOCK_STABLE_CYCLES edges after STABILIZE entry.
- A lock glitch shorter than one refclk period may be missed. This is acceptable; the stability window covers it.

Test Plan:
Use params RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2 unless stated.
1. Nominal: release rst, pll_locked rises 10 cycles after pll_rst falls -> pll_rst high exactly 4 cycles; STABILIZE 3 cycles after lock; ready=1 and sys_rst=0 8 cycles later; retry_count=0.
2. Timeouts: pll_locked held 0 -> three 32-cycle WAIT_LOCK windows separated by 4-cycle pll_rst pulses; retry_count 0->1->2; then FAULT with fault=1 and pll_rst=1 held; pulse req_relock -> RESET_PLL, fault=0, retry_count=0.
3. Unstable lock: in STABILIZE drop pll_locked for 2 cycles at stable-count 5 -> back to WAIT_LOCK, ready stays 0, retry_count unchanged; re-lock -> full 8-cycle window required before ready.
4. Loss of lock in RUN: drop pll_locked -> 3 edges later sys_rst=1, ready=0, lol_count=1, state=RESET_PLL; repeat 300 times -> lol_count saturates at 255.
5. Reset mid-operation: assert rst during STABILIZE and during RUN -> next edge all outputs at reset values, lol_count=0.
6. req_relock in RUN with pll_locked stable -> RESET_PLL next edge, sys_rst=1, lol_count unchanged; the sequence completes again to ready=1.
